// File: rtl/note_highway_fsm.sv
// Note-highway control engine: clears the lane grid, fetches note rows from the song ROM and
// streams box pixels to the VGA plot port. Define HIGHWAY_LOOP_EN to wrap playback at song end.
module note_highway_fsm #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned BOX_W     = 8,
  parameter int unsigned BOX_H     = 4,
  parameter int unsigned SONG_LEN  = 64,
  parameter int unsigned X0        = 16,
  parameter int unsigned Y0        = 8,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  localparam int unsigned AW       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             beat_tick_i,
  input  logic [LANES-1:0] note_bits_i,
  output logic [AW-1:0]    song_addr_o,
  output logic [X_W-1:0]   x_o,
  output logic [Y_W-1:0]   y_o,
  output logic [2:0]       colour_o,
  output logic             plot_o,
  output logic             busy_o,
  output logic             song_done_o,
  output logic             missed_beat_o
);

  localparam int unsigned LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int unsigned PYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam int unsigned CXN = LANES * BOX_W;
  localparam int unsigned CYN = ROWS * BOX_H;
  localparam int unsigned CXW = (CXN > 1) ? $clog2(CXN) : 1;
  localparam int unsigned CYW = (CYN > 1) ? $clog2(CYN) : 1;
  localparam int unsigned BW  = $clog2(SONG_LEN + 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StFetch, StFetchWait, StDraw, StWaitBeat, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             pending_q, pending_d;
  logic [RW-1:0]    row_q, row_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [PXW-1:0]   px_q, px_d;
  logic [PYW-1:0]   py_q, py_d;
  logic [CXW-1:0]   cx_q, cx_d;
  logic [CYW-1:0]   cy_q, cy_d;
  logic [LANES-1:0] notes_q, notes_d;
  logic [AW-1:0]    song_addr_q, song_addr_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d, busy_q, busy_d, done_q, done_d, missed_q, missed_d;
  logic [31:0]      fetch_sum, next_sum;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pending_d = pending_q;
    row_d     = row_q;
    lane_d    = lane_q;
    px_d      = px_q;
    py_d      = py_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    notes_d   = notes_q;
    missed_d  = 1'b0;
    fetch_sum = 32'(beat_q) + 32'(row_q);

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StClear;
          beat_d    = '0;
          pending_d = 1'b0;
          cx_d      = '0;
          cy_d      = '0;
        end
      end
      StClear: begin
        if (cx_q != CXW'(CXN - 1)) begin
          cx_d = cx_q + CXW'(1);
        end else begin
          cx_d = '0;
          if (cy_q != CYW'(CYN - 1)) begin
            cy_d = cy_q + CYW'(1);
          end else begin
            row_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: state_d = StFetchWait;
      StFetchWait: begin
        // Rows past the end of the song draw as empty boxes.
        notes_d = (fetch_sum >= 32'(SONG_LEN)) ? '0 : note_bits_i;
        lane_d  = '0;
        px_d    = '0;
        py_d    = '0;
        state_d = StDraw;
      end
      StDraw: begin
        if (px_q != PXW'(BOX_W - 1)) begin
          px_d = px_q + PXW'(1);
        end else begin
          px_d = '0;
          if (py_q != PYW'(BOX_H - 1)) begin
            py_d = py_q + PYW'(1);
          end else begin
            py_d = '0;
            if (lane_q != LW'(LANES - 1)) begin
              lane_d = lane_q + LW'(1);
            end else if (row_q == RW'(ROWS - 1)) begin
              state_d = StWaitBeat;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = StFetch;
            end
          end
        end
      end
      StWaitBeat: begin
        if (pending_q || beat_tick_i) begin
          pending_d = 1'b0;
          missed_d  = pending_q && beat_tick_i;
          row_d     = '0;
          if (beat_q == BW'(SONG_LEN - 1)) begin
`ifdef HIGHWAY_LOOP_EN
            beat_d  = '0;
            state_d = StFetch;
`else
            beat_d  = BW'(SONG_LEN);
            state_d = StDone;
`endif
          end else begin
            beat_d  = beat_q + BW'(1);
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Ticks arriving mid-frame are banked; a second one before it is consumed is an overrun.
    if (beat_tick_i && (state_q inside {StClear, StFetch, StFetchWait, StDraw})) begin
      if (pending_q) missed_d = 1'b1;
      else           pending_d = 1'b1;
    end

    // Outputs are registered from the next state so plot lines up with CLEAR/DRAW cycles.
    song_addr_d = song_addr_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    next_sum    = 32'(beat_d) + 32'(row_d);
    if (state_d == StFetch) song_addr_d = AW'(next_sum);
    if (state_d == StClear) begin
      plot_d   = 1'b1;
      x_d      = X_W'(X0) + X_W'(cx_d);
      y_d      = Y_W'(Y0) + Y_W'(cy_d);
      colour_d = BG_COLOUR;
    end else if (state_d == StDraw) begin
      plot_d   = 1'b1;
      x_d      = X_W'(X0) + X_W'(lane_d) * X_W'(BOX_W) + X_W'(px_d);
      y_d      = Y_W'(Y0) + (Y_W'(ROWS - 1) - Y_W'(row_d)) * Y_W'(BOX_H) + Y_W'(py_d);
      colour_d = notes_d[lane_d] ? (3'(lane_d) + 3'd1) : BG_COLOUR;
    end
    busy_d = !(state_d inside {StIdle, StDone});
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      pending_q   <= 1'b0;
      row_q       <= '0;
      lane_q      <= '0;
      px_q        <= '0;
      py_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      notes_q     <= '0;
      song_addr_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pending_q   <= pending_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
      px_q        <= px_d;
      py_q        <= py_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      notes_q     <= notes_d;
      song_addr_q <= song_addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      missed_q    <= missed_d;
    end
  end

  assign song_addr_o   = song_addr_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign colour_o      = colour_q;
  assign plot_o        = plot_q;
  assign busy_o        = busy_q;
  assign song_done_o   = done_q;
  assign missed_beat_o = missed_q;

endmodule

// File: tb/tb_note_highway_fsm.sv
// Bench for note_highway_fsm: pixel-probe table, multi-cycle corner sequences and a random
// song checked against a formula-based frame model. Honours HIGHWAY_LOOP_EN for the end test.
module tb_note_highway_fsm;

  localparam int CLR = 1024;  // clear plots with default geometry
  localparam int FRM = 1024;  // plots per frame

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [3:0] notes;
    int         idx;
    int         ex;
    int         ey;
    int         ec;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, start_a = 1'b0, tick_a = 1'b0;
  logic [3:0] note_a = '0;
  logic [5:0] addr_a;
  logic [7:0] x_a;
  logic [6:0] y_a;
  logic [2:0] col_a;
  logic       plot_a, busy_a, done_a, miss_a;

  logic       rst_b = 1'b1, start_b = 1'b0, tick_b = 1'b0;
  logic [3:0] note_b = '0;
  logic [1:0] addr_b;
  logic [7:0] x_b;
  logic [6:0] y_b;
  logic [2:0] col_b;
  logic       plot_b, busy_b, done_b, miss_b;

  logic [3:0] rom_a [64];
  logic [3:0] rom_b [4];

  note_highway_fsm dut (
    .clock_i(clk), .reset_i(rst_a), .start_i(start_a), .beat_tick_i(tick_a),
    .note_bits_i(note_a), .song_addr_o(addr_a), .x_o(x_a), .y_o(y_a), .colour_o(col_a),
    .plot_o(plot_a), .busy_o(busy_a), .song_done_o(done_a), .missed_beat_o(miss_a)
  );

  note_highway_fsm #(.SONG_LEN(4)) dut_s (
    .clock_i(clk), .reset_i(rst_b), .start_i(start_b), .beat_tick_i(tick_b),
    .note_bits_i(note_b), .song_addr_o(addr_b), .x_o(x_b), .y_o(y_b), .colour_o(col_b),
    .plot_o(plot_b), .busy_o(busy_b), .song_done_o(done_b), .missed_beat_o(miss_b)
  );

  // Synchronous song ROMs, one cycle of latency.
  always @(posedge clk) begin
    note_a <= rom_a[addr_a];
    note_b <= rom_b[addr_b];
  end

  pix_t got_a[$], got_b[$];
  int   flog_a[$], flog_b[$];  // song_addr at the first plot of each frame
  int   miss_cnt_a = 0, miss_cnt_b = 0;
  bit   done_seen_b = 1'b0;
  int   checks = 0, errors = 0;
  int   exp_beats[$];

  always @(negedge clk) begin
    if (plot_a) begin
      if (got_a.size() >= CLR && (got_a.size() - CLR) % FRM == 0) flog_a.push_back(int'(addr_a));
      got_a.push_back({x_a, y_a, col_a});
    end
    if (plot_b) begin
      if (got_b.size() >= CLR && (got_b.size() - CLR) % FRM == 0) flog_b.push_back(int'(addr_b));
      got_b.push_back({x_b, y_b, col_b});
    end
    if (miss_a) miss_cnt_a++;
    if (miss_b) miss_cnt_b++;
    if (done_b) done_seen_b = 1'b1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qsize(input bit b);
    return b ? got_b.size() : got_a.size();
  endfunction

  task automatic wait_size(input bit b, input int n, input int budget, input string name);
    int t = 0;
    while (qsize(b) < n && t < budget) begin
      step();
      t++;
    end
    check({name, " reached"}, 32'(qsize(b) >= n), 1);
  endtask

  task automatic reset_dut(input bit b);
    if (b) rst_b = 1'b1; else rst_a = 1'b1;
    step();
    step();
    if (b) begin got_b.delete(); flog_b.delete(); miss_cnt_b = 0; done_seen_b = 1'b0; end
    else   begin got_a.delete(); flog_a.delete(); miss_cnt_a = 0; end
    if (b) rst_b = 1'b0; else rst_a = 1'b0;
    step();
  endtask

  task automatic pulse_start(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic pulse_tick(input bit b);
    if (b) tick_b = 1'b1; else tick_a = 1'b1;
    step();
    tick_a = 1'b0;
    tick_b = 1'b0;
  endtask

  function automatic pix_t clear_pix(input int i);
    pix_t p;
    p.x = 8'(16 + i % 32);
    p.y = 7'(8 + i / 32);
    p.c = 3'd0;
    return p;
  endfunction

  // Pixel i of the frame drawn at beat `beat`, straight from the highway geometry.
  function automatic pix_t exp_pix(input bit b, input int beat, input int i);
    pix_t       p;
    int         row, rem, lane, py, px, addr;
    logic [3:0] n;
    row  = i / 128;
    rem  = i % 128;
    lane = rem / 32;
    py   = (rem % 32) / 8;
    px   = rem % 8;
    addr = beat + row;
    n    = 4'd0;
    if (b) begin
      if (addr < 4) n = rom_b[addr];
    end else begin
      if (addr < 64) n = rom_a[addr];
    end
    p.x = 8'(16 + lane * 8 + px);
    p.y = 7'(8 + (7 - row) * 4 + py);
    p.c = n[lane] ? 3'(lane + 1) : 3'd0;
    return p;
  endfunction

  function automatic pix_t get_pix(input bit b, input int i);
    if (i >= qsize(b)) return '0;
    return b ? got_b[i] : got_a[i];
  endfunction

  task automatic check_stream(input bit b, input string tag);
    int bad;
    check({tag, " plot count"}, 32'(qsize(b)), 32'(CLR + FRM * exp_beats.size()));
    bad = 0;
    for (int i = 0; i < CLR; i++) if (get_pix(b, i) !== clear_pix(i)) bad++;
    check({tag, " clear pixels bad"}, 32'(bad), 0);
    foreach (exp_beats[k]) begin
      bad = 0;
      for (int i = 0; i < FRM; i++)
        if (get_pix(b, CLR + k * FRM + i) !== exp_pix(b, exp_beats[k], i)) bad++;
      check($sformatf("%s frame%0d pixels bad", tag, k), 32'(bad), 0);
    end
  endtask

  vec_t vecs [10];

  initial begin
    int   run, cyc, gap, t, exp_miss, off, n;
    pix_t p;

    vecs[0] = '{4'b0101, 0,          16, 8,  0};
    vecs[1] = '{4'b0101, 1023,       47, 39, 0};
    vecs[2] = '{4'b0101, 1024,       16, 36, 1};
    vecs[3] = '{4'b0101, 1024 + 31,  23, 39, 1};
    vecs[4] = '{4'b0101, 1024 + 32,  24, 36, 0};
    vecs[5] = '{4'b0101, 1024 + 64,  32, 36, 3};
    vecs[6] = '{4'b0101, 1024 + 127, 47, 39, 0};
    vecs[7] = '{4'b1010, 1024 + 127, 47, 39, 4};
    vecs[8] = '{4'b1010, 1024 + 40,  24, 37, 2};
    vecs[9] = '{4'b1111, 1024 + 128, 16, 32, 0};
    for (int i = 0; i < 64; i++) rom_a[i] = 4'd0;
    for (int i = 0; i < 4; i++) rom_b[i] = 4'($urandom_range(0, 15));

    // Reset values
    repeat (3) step();
    check("reset plot", plot_a, 0);
    check("reset busy", busy_a, 0);
    check("reset x", x_a, 0);
    check("reset y", y_a, 0);
    check("reset colour", col_a, 0);
    check("reset song_addr", addr_a, 0);
    check("reset song_done", done_a, 0);
    check("reset missed", miss_a, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();

    // Reset held three cycles mid-draw
    pulse_start(1'b0);
    wait_size(1'b0, 1200, 3000, "middraw");
    rst_a = 1'b1;
    step();
    check("midreset plot", plot_a, 0);
    check("midreset busy", busy_a, 0);
    n = got_a.size();
    step();
    step();
    rst_a = 1'b0;
    step();
    check("midreset no further plot", 32'(got_a.size()), 32'(n));
    check("midreset idle busy", busy_a, 0);
    check("midreset x", x_a, 0);
    check("midreset y", y_a, 0);

    // Pixel probe table
    foreach (vecs[v]) begin
      reset_dut(1'b0);
      rom_a[0] = vecs[v].notes;
      pulse_start(1'b0);
      wait_size(1'b0, vecs[v].idx + 1, 2500, $sformatf("vec%0d", v));
      p = get_pix(1'b0, vecs[v].idx);
      check($sformatf("vec%0d x", v), p.x, vecs[v].ex);
      check($sformatf("vec%0d y", v), p.y, vecs[v].ey);
      check($sformatf("vec%0d colour", v), p.c, vecs[v].ec);
    end

    // Clear run, frame length and render content
    reset_dut(1'b0);
    rom_a[0] = 4'b0101;
    pulse_start(1'b0);
    check("start to first plot", plot_a, 1);
    run = 0;
    t = 0;
    while (plot_a && t < 3000) begin
      run++;
      step();
      t++;
    end
    check("clear run length", 32'(run), CLR);
    cyc = 1;
    while (got_a.size() < CLR + FRM && cyc < 3000) begin
      step();
      cyc++;
    end
    check("frame cycles", 32'(cyc), 1040);
    repeat (5) step();
    check("waits for beat", 32'(got_a.size()), CLR + FRM);
    check("busy in wait", busy_a, 1);

    // Overrun: two ticks within one frame
    pulse_tick(1'b0);
    wait_size(1'b0, CLR + FRM + 100, 2000, "frame1 start");
    pulse_tick(1'b0);
    repeat (50) step();
    pulse_tick(1'b0);
    step();
    step();
    check("missed pulses", 32'(miss_cnt_a), 1);
    wait_size(1'b0, CLR + 2 * FRM, 2000, "frame1 end");
    gap = 0;
    t = 0;
    step();
    while (!plot_a && t < 20) begin
      gap++;
      step();
      t++;
    end
    check("gap after banked beat", 32'(gap), 3);
    check("beat after overrun", addr_a, 2);
    wait_size(1'b0, CLR + 3 * FRM, 2000, "frame2 end");
    repeat (50) step();
    check("no extra beat", 32'(got_a.size()), CLR + 3 * FRM);
    check("missed total", 32'(miss_cnt_a), 1);
    exp_beats = '{0, 1, 2};
    check_stream(1'b0, "overrun");

    // Random song with random tick placement, occasional double ticks
    for (int i = 0; i < 64; i++) rom_a[i] = 4'($urandom_range(0, 15));
    reset_dut(1'b0);
    pulse_start(1'b0);
    exp_beats = '{0};
    exp_miss = 0;
    for (int k = 1; k <= 5; k++) begin
      off = $urandom_range(10, 500);
      wait_size(1'b0, CLR + (k - 1) * FRM + off, 3000, $sformatf("rand tick%0d", k));
      pulse_tick(1'b0);
      if ($urandom_range(0, 1) == 1) begin
        off = off + $urandom_range(20, 300);
        wait_size(1'b0, CLR + (k - 1) * FRM + off, 3000, $sformatf("rand dbl%0d", k));
        pulse_tick(1'b0);
        exp_miss++;
      end
      exp_beats.push_back(k);
    end
    wait_size(1'b0, CLR + 6 * FRM, 3000, "rand last");
    repeat (20) step();
    check("rand missed", 32'(miss_cnt_a), 32'(exp_miss));
    check_stream(1'b0, "random");

    // Song end (SONG_LEN = 4)
    reset_dut(1'b1);
    pulse_start(1'b1);
`ifdef HIGHWAY_LOOP_EN
    exp_beats = '{0, 1, 2, 3, 0, 1, 2};
    for (int k = 1; k <= 6; k++) begin
      wait_size(1'b1, CLR + (k - 1) * FRM + 200, 3000, $sformatf("loop tick%0d", k));
      pulse_tick(1'b1);
    end
    wait_size(1'b1, CLR + 7 * FRM, 3000, "loop last");
    repeat (20) step();
    check("loop song_done never", 32'(done_seen_b), 0);
    check("loop busy", busy_b, 1);
    check("loop wrap addr", 32'((flog_b.size() > 4) ? flog_b[4] : 99), 0);
    check_stream(1'b1, "loop");
`else
    exp_beats = '{0, 1, 2, 3};
    for (int k = 1; k <= 4; k++) begin
      wait_size(1'b1, CLR + (k - 1) * FRM + 200, 3000, $sformatf("end tick%0d", k));
      pulse_tick(1'b1);
    end
    t = 0;
    while (!done_b && t < 2000) begin
      step();
      t++;
    end
    check("song_done", done_b, 1);
    check("busy at done", busy_b, 0);
    check_stream(1'b1, "end");
    got_b.delete();
    flog_b.delete();
    pulse_start(1'b1);
    check("restart song_done", done_b, 0);
    check("restart busy", busy_b, 1);
    wait_size(1'b1, CLR + 1, 3000, "restart frame");
    check("restart beat", 32'((flog_b.size() > 0) ? flog_b[0] : 99), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
